// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch buffer: issues sequential word fetches and buffers returned
// instructions with their PCs in an in-order show-ahead queue. Redirects flush everything.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic          empty, room, gnt_fire, rsp_fire, push, pop;

  // Reserving a slot for every in-flight request means a response can always be pushed.
  assign empty = (count_q == '0);
  assign room  = ((32'(count_q) + 32'(outstanding_q)) < DEPTH) &&
                 (32'(outstanding_q) < MAX_OUTSTANDING);

  assign mem_req_o     = !reset && !redirect_i && room;
  assign mem_addr_o    = fetch_pc_q;
  assign instr_valid_o = !reset && !empty && !redirect_i;
  assign instr_o       = empty ? '0 : instr_mem_q[rd_ptr_q];
  assign pc_o          = empty ? '0 : pc_mem_q[rd_ptr_q];

  assign gnt_fire = mem_req_o && mem_gnt_i;
  assign rsp_fire = mem_rvalid_i && (outstanding_q != '0);
  assign push     = rsp_fire && !redirect_i && (discard_q == '0);
  assign pop      = instr_valid_o && !stall_i;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;

    if (gnt_fire) outstanding_d = outstanding_d + OW'(1);
    if (rsp_fire) outstanding_d = outstanding_d - OW'(1);

    if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      discard_d  = outstanding_d;
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      rsp_pc_d   = {redirect_pc_i[31:2], 2'b00};
    end else begin
      if (rsp_fire && (discard_q != '0)) discard_d = discard_q - OW'(1);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
      if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_mem_q[wr_ptr_q] <= mem_rdata_i;
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue: an in-order memory model drives the bus and a
// queue-based reference tracks in-flight requests (marked stale on redirect) and buffered entries.
module tb_fetch_prefetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  fetch_prefetch_queue #(
    .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .stall_i(stall_i),
    .instr_valid_o(instr_valid_o),
    .instr_o(instr_o),
    .pc_o(pc_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int unsigned ready; } mreq_t;

  infl_t       inflight[$];
  ent_t        buffer[$];
  mreq_t       mem_q[$];
  logic [31:0] m_fetch_pc;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit redir, input logic [31:0] tgt, input bit stall,
                      input int unsigned gnt_pct, input int unsigned rv_pct);
    bit          exp_req, exp_v, rv;
    logic [31:0] rdata;
    infl_t       e;
    ent_t        n;
    mreq_t       m;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    stall_i       = stall;
    // Grant only once stale responses from before a reset have drained.
    mem_gnt_i = ($urandom_range(99) < gnt_pct) && (mem_q.size() == inflight.size());
    rv = 1'b0;
    if (mem_q.size() != 0)
      if (mem_q[0].ready <= cyc && $urandom_range(99) < rv_pct) rv = 1'b1;
    rdata        = rv ? (mem_q[0].addr ^ KEY) : $urandom;
    mem_rvalid_i = rv;
    mem_rdata_i  = rdata;
    #1;
    exp_req = !redir && (buffer.size() + inflight.size() < DEPTH) && (inflight.size() < MAXO);
    check("mem_req", {31'b0, mem_req_o}, {31'b0, exp_req});
    if (exp_req) check("mem_addr", mem_addr_o, m_fetch_pc);
    exp_v = (buffer.size() != 0) && !redir;
    check("instr_valid", {31'b0, instr_valid_o}, {31'b0, exp_v});
    if (exp_v) begin
      check("pc", pc_o, buffer[0].pc);
      check("instr", instr_o, buffer[0].instr);
    end
    @(posedge clk);
    if (exp_v && !stall) void'(buffer.pop_front());
    if (rv) begin
      void'(mem_q.pop_front());
      if (inflight.size() != 0) begin
        e = inflight.pop_front();
        if (!e.stale && !redir) begin
          n.pc = e.addr; n.instr = rdata;
          buffer.push_back(n);
        end
      end
    end
    if (redir) begin
      buffer.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      m_fetch_pc = tgt & 32'hFFFF_FFFC;
    end
    if (exp_req && mem_gnt_i) begin
      e.addr = m_fetch_pc; e.stale = 1'b0;
      inflight.push_back(e);
      m.addr = m_fetch_pc; m.ready = cyc + 1;
      mem_q.push_back(m);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    redirect_i   = 1'b0;
    stall_i      = 1'b0;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b0;
    @(posedge clk);
    buffer.delete();
    inflight.delete();
    m_fetch_pc = RPC;
    cyc++;
    @(negedge clk);
    #1;
    check("rst_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    reset = 1'b0;
  endtask

  task automatic run(input int unsigned n, input bit stall, input int unsigned gp, input int unsigned rp);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 32'd0, stall, gp, rp);
  endtask

  initial begin
    reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    m_fetch_pc = RPC;
    @(negedge clk);
    do_reset();

    run(12, 1'b0, 100, 100);                 // streaming
    run(12, 1'b1, 100, 100);                 // stall fills the queue
    run(10, 1'b0, 100, 100);                 // drain without gaps
    run(5, 1'b1, 0, 100);                    // grant withheld: request must hold steady
    run(4, 1'b0, 100, 100);

    run(3, 1'b0, 100, 0);                    // build outstanding requests
    step(1'b1, 32'h0000_0100, 1'b0, 100, 0);
    run(10, 1'b0, 100, 100);

    run(2, 1'b0, 100, 0);
    step(1'b0, 32'd0, 1'b0, 100, 100);       // queue non-empty with requests in flight
    step(1'b1, 32'h0000_0103, 1'b0, 100, 100);
    run(10, 1'b0, 100, 100);

    step(1'b1, 32'hFFFF_FFF8, 1'b0, 100, 100);
    run(10, 1'b0, 100, 100);                 // PC wrap through zero

    run(3, 1'b1, 100, 0);                    // reset with responses still due
    do_reset();
    run(12, 1'b0, 100, 100);

    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) do_reset();
      else step($urandom_range(99) < 4, $urandom, $urandom_range(99) < 30,
                $urandom_range(100), $urandom_range(100));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
